spram_arbiter: RTL and testbench

//  Shares the single-port byte-wide SPRAM (mem instance: addr/write/data_in/data_out,
//  1-cycle read latency) between two requesters, e.g. a UART loader and a dump/CPU port.

---
 rtl/spram_arbiter_if.sv | 17 +
 rtl/spram_arbiter.sv | 112 +++++++++++
 tb/tb_spram_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spram_arbiter_if.sv
// One requester port of the SPRAM arbiter: request/command in, grant and
// read-return strobe out. rdata is the shared memory output, qualified by rvalid.
interface spram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/spram_arbiter.sv
// Two-port weighted round-robin arbiter in front of a single-port byte SPRAM
// with a registered command stage and per-port read-valid return.
module spram_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    spram_arbiter_if.slave      p0,
    spram_arbiter_if.slave      p1,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_data_in,
    input  logic [DATA_W-1:0]   mem_data_out
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic              owner_q, owner_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_write_q, mem_write_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_port_q, rd_port_d;
    logic [1:0]        rvalid_q, rvalid_d;

    logic [1:0]        gnt;
    logic              pick, hs, hs_port, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Under contention the owner keeps the bus until its burst is used up.
    always_comb begin
        gnt  = '0;
        pick = 1'b0;
        if (!rst) begin
            if (p0.req && p1.req) begin
                pick      = (burst_q < BURST_MAX) ? owner_q : ~owner_q;
                gnt[pick] = 1'b1;
            end else begin
                gnt[0] = p0.req;
                gnt[1] = p1.req;
            end
        end
    end

    assign hs        = |gnt;
    assign hs_port   = gnt[1];
    assign sel_we    = hs_port ? p1.we    : p0.we;
    assign sel_addr  = hs_port ? p1.addr  : p0.addr;
    assign sel_wdata = hs_port ? p1.wdata : p0.wdata;

    always_comb begin
        owner_d     = owner_q;
        burst_d     = burst_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_write_d = 1'b0;
        rd_vld_d    = 1'b0;
        rd_port_d   = rd_port_q;
        rvalid_d    = '0;
        if (hs) begin
            if (hs_port == owner_q) begin
                if (burst_q < BURST_MAX) burst_d = burst_q + 1'b1;
            end else begin
                owner_d = hs_port;
                burst_d = BW'(1);
            end
            mem_addr_d  = sel_addr;
            mem_data_d  = sel_wdata;
            mem_write_d = sel_we;
            rd_vld_d    = ~sel_we;
            rd_port_d   = hs_port;
        end
        // Memory output is valid the cycle after the command is presented.
        rvalid_d[rd_port_q] = rd_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b1;
            burst_q     <= BURST_MAX;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_port_q   <= 1'b0;
            rvalid_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_write_q <= mem_write_d;
            rd_vld_q    <= rd_vld_d;
            rd_port_q   <= rd_port_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign p0.gnt      = gnt[0];
    assign p1.gnt      = gnt[1];
    assign p0.rvalid   = rvalid_q[0];
    assign p1.rvalid   = rvalid_q[1];
    assign p0.rdata    = mem_data_out;
    assign p1.rdata    = mem_data_out;
    assign mem_addr    = mem_addr_q;
    assign mem_write   = mem_write_q;
    assign mem_data_in = mem_data_q;
endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: SPRAM behavioural model, read-return scoreboard,
// grant-order vector table (MAX_BURST=4 and a MAX_BURST=1 twin) and corner sequences.
module tb_spram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) p0_if ();
    spram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) p1_if ();
    spram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) q0_if ();
    spram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) q1_if ();

    logic [14:0] mem_addr, q_mem_addr;
    logic        mem_write, q_mem_write;
    logic [7:0]  mem_data_in, q_mem_data_in;
    logic [7:0]  mem_data_out;
    logic [7:0]  q_mem_data_out = 8'h00;

    spram_arbiter #(.ADDR_W(15), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
        .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out));

    spram_arbiter #(.ADDR_W(15), .DATA_W(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .p0(q0_if), .p1(q1_if),
        .mem_addr(q_mem_addr), .mem_write(q_mem_write),
        .mem_data_in(q_mem_data_in), .mem_data_out(q_mem_data_out));

    // Single-port SPRAM, 1-cycle read latency, not reset.
    logic [7:0] mem [0:32767];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    typedef struct { logic port; logic [7:0] data; } sb_t;
    typedef struct { logic r0; logic r1; logic [1:0] eg; logic [1:0] eh; } vec_t;

    sb_t        sbq[$];
    logic [7:0] ref_mem [int];
    int         nchk = 0;
    int         nfail = 0;
    int         run1 = 0;
    int         max_run1 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle on the main DUT, sample grants mid-cycle, record handshakes.
    task automatic cyc(input logic r0, input logic w0, input logic [14:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [14:0] a1, input logic [7:0] d1,
                       output logic [3:0] g);
        sb_t e;
        p0_if.req = r0; p0_if.we = w0; p0_if.addr = a0; p0_if.wdata = d0;
        p1_if.req = r1; p1_if.we = w1; p1_if.addr = a1; p1_if.wdata = d1;
        @(negedge clk);
        g = {q1_if.gnt, q0_if.gnt, p1_if.gnt, p0_if.gnt};
        chk("gnt_onehot", {31'd0, g[0] & g[1]}, 0);
        if (r0 && g[0]) begin
            if (w0) ref_mem[int'(a0)] = d0;
            else begin e.port = 1'b0; e.data = ref_mem[int'(a0)]; sbq.push_back(e); end
        end
        if (r1 && g[1]) begin
            if (w1) ref_mem[int'(a1)] = d1;
            else begin e.port = 1'b1; e.data = ref_mem[int'(a1)]; sbq.push_back(e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [3:0] g;
        repeat (n) cyc(1'b0, 1'b0, 15'd0, 8'd0, 1'b0, 1'b0, 15'd0, 8'd0, g);
    endtask

    // Reset with both ports hammering writes: nothing may be granted.
    task automatic do_reset(input int n);
        logic [3:0] g;
        rst = 1'b1;
        sbq.delete();
        repeat (n) begin
            cyc(1'b1, 1'b1, 15'h123, 8'hEE, 1'b1, 1'b1, 15'h456, 8'hDD, g);
            chk("gnt_in_rst", {28'd0, g[1:0]}, 0);
        end
        rst = 1'b0;
        chk("rst_mem_write", {31'd0, mem_write}, 0);
        chk("rst_mem_addr", {17'd0, mem_addr}, 0);
        chk("rst_mem_data_in", {24'd0, mem_data_in}, 0);
        chk("rst_rvalid", {30'd0, p1_if.rvalid, p0_if.rvalid}, 0);
    endtask

    // Read-return monitor against the scoreboard.
    always @(negedge clk) begin
        sb_t e;
        if (p0_if.rvalid || p1_if.rvalid) begin
            nchk++;
            if (p0_if.rvalid && p1_if.rvalid) begin
                nfail++;
                $display("FAIL rvalid_both: both rvalids high at %0t", $time);
            end else if (sbq.size() == 0) begin
                nfail++;
                $display("FAIL rvalid_spurious: p0=%0b p1=%0b with nothing outstanding at %0t",
                         p0_if.rvalid, p1_if.rvalid, $time);
            end else begin
                e = sbq.pop_front();
                if (p1_if.rvalid != e.port || p0_if.rdata != e.data) begin
                    nfail++;
                    $display("FAIL rdata: got port %0d data 0x%0h expected port %0d data 0x%0h at %0t",
                             p1_if.rvalid, p0_if.rdata, e.port, e.data, $time);
                end
            end
        end
        if (p1_if.rvalid) run1++;
        else run1 = 0;
        if (run1 > max_run1) max_run1 = run1;
    end

    initial begin
        vec_t       tbl [14];
        logic [3:0] g;
        logic [14:0] held;

        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 1'b1, (i >= 4 && i < 8) ? 2'b10 : 2'b01, i[0] ? 2'b10 : 2'b01};
        tbl[10] = '{1'b1, 1'b0, 2'b01, 2'b01};
        tbl[11] = '{1'b0, 1'b1, 2'b10, 2'b10};
        tbl[12] = '{1'b1, 1'b1, 2'b10, 2'b01};
        tbl[13] = '{1'b0, 1'b0, 2'b00, 2'b00};

        q0_if.req = 1'b0; q0_if.we = 1'b1; q0_if.addr = 15'd0; q0_if.wdata = 8'd0;
        q1_if.req = 1'b0; q1_if.we = 1'b1; q1_if.addr = 15'd0; q1_if.wdata = 8'd0;

        do_reset(2);

        // Write then read back on port 0.
        cyc(1'b1, 1'b1, 15'h0000, 8'h41, 1'b0, 1'b0, 15'd0, 8'd0, g);
        chk("t1_gnt_wr", {31'd0, g[0]}, 1);
        chk("t1_mem_write", {31'd0, mem_write}, 1);
        chk("t1_mem_addr", {17'd0, mem_addr}, 0);
        chk("t1_mem_data_in", {24'd0, mem_data_in}, 'h41);
        cyc(1'b1, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 15'd0, 8'd0, g);
        chk("t1_gnt_rd", {31'd0, g[0]}, 1);
        chk("t1_mem_write_once", {31'd0, mem_write}, 0);
        chk("t1_rvalid_early", {31'd0, p0_if.rvalid}, 0);
        idle(1);
        chk("t1_rvalid_lat", {31'd0, p0_if.rvalid}, 1);
        chk("t1_rdata", {24'd0, p0_if.rdata}, 'h41);
        idle(1);
        chk("t1_rvalid_drop", {31'd0, p0_if.rvalid}, 0);

        // Grant order under contention, both burst settings.
        do_reset(1);
        for (int i = 0; i < 14; i++) begin
            q0_if.req = tbl[i].r0;
            q1_if.req = tbl[i].r1;
            cyc(tbl[i].r0, 1'b1, 15'(32'h100 + i), 8'(i), tbl[i].r1, 1'b1, 15'(32'h200 + i), 8'(i), g);
            chk($sformatf("t2_gnt_mb4[%0d]", i), {30'd0, g[1:0]}, {30'd0, tbl[i].eg});
            chk($sformatf("t2_gnt_mb1[%0d]", i), {30'd0, g[3:2]}, {30'd0, tbl[i].eh});
        end
        q0_if.req = 1'b0;
        q1_if.req = 1'b0;
        idle(2);

        // Preload 'A'..'F' then port 1 streams six back-to-back reads.
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b1, 15'(i), 8'(32'h41 + i), 1'b0, 1'b0, 15'd0, 8'd0, g);
        max_run1 = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 1'b0, 15'(i), 8'd0, g);
            chk($sformatf("t3_gnt_p1[%0d]", i), {31'd0, g[1]}, 1);
        end
        idle(3);
        chk("t3_rvalid_run", max_run1, 6);

        // Top-address write from port 0 then immediate read from port 1.
        cyc(1'b1, 1'b1, 15'h7FFF, 8'h5A, 1'b0, 1'b0, 15'd0, 8'd0, g);
        chk("t4_mem_addr", {17'd0, mem_addr}, 'h7FFF);
        cyc(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 1'b0, 15'h7FFF, 8'd0, g);
        chk("t4_gnt_p1", {31'd0, g[1]}, 1);
        idle(1);
        chk("t4_p1_rvalid", {31'd0, p1_if.rvalid}, 1);
        chk("t4_rdata", {24'd0, p1_if.rdata}, 'h5A);
        idle(2);

        // Reset right after a read handshake cancels its return.
        cyc(1'b0, 1'b0, 15'd0, 8'd0, 1'b1, 1'b0, 15'h0003, 8'd0, g);
        do_reset(1);
        idle(2);
        cyc(1'b1, 1'b1, 15'h0010, 8'h77, 1'b1, 1'b1, 15'h0011, 8'h88, g);
        chk("t5_first_contention", {30'd0, g[1:0]}, 1);

        // Idle: no writes, address holds.
        held = mem_addr;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk($sformatf("t6_mem_write[%0d]", i), {31'd0, mem_write}, 0);
            chk($sformatf("t6_mem_addr[%0d]", i), {17'd0, mem_addr}, {17'd0, held});
        end

        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
